// File: rtl/core_types_pkg.sv
// Shared rename-stage types for the physical-register free list.
// Holds the register-file sizing, tag / checkpoint / pointer typedefs and the
// enqueue payload struct used by the free list and its checkpoint array.
package core_types_pkg;

  localparam int unsigned NUM_PHYS_REGS       = 64;
  localparam int unsigned NUM_ARCH_REGS       = 32;
  localparam int unsigned FREE_LIST_DEPTH     = NUM_PHYS_REGS - NUM_ARCH_REGS;
  localparam int unsigned LOG_FREE_LIST_DEPTH = $clog2(FREE_LIST_DEPTH);
  localparam int unsigned PHYS_REG_TAG_W      = $clog2(NUM_PHYS_REGS);
  localparam int unsigned CHECKPOINT_COLUMNS  = 4;
  localparam int unsigned CHECKPOINT_COLUMN_W = $clog2(CHECKPOINT_COLUMNS);
  localparam int unsigned FREE_COUNT_W        = LOG_FREE_LIST_DEPTH + 1;

  typedef logic [PHYS_REG_TAG_W-1:0]      phys_reg_tag_t;
  typedef logic [CHECKPOINT_COLUMN_W-1:0] checkpoint_column_t;
  // MSB is the wrap bit; low bits index the circular array.
  typedef logic [LOG_FREE_LIST_DEPTH:0]   free_list_ptr_t;
  typedef logic [FREE_COUNT_W-1:0]        free_count_t;

  // Freed tag returned by commit.
  typedef struct packed {
    logic          valid;
    phys_reg_tag_t tag;
  } free_list_enq_t;

  // Array index carried in the low bits of a pointer.
  function automatic logic [LOG_FREE_LIST_DEPTH-1:0] ptr_idx(input free_list_ptr_t ptr);
    return ptr[LOG_FREE_LIST_DEPTH-1:0];
  endfunction

endpackage

// File: rtl/phys_reg_free_list_ckpt_if.sv
// Rename/commit-side interface of the checkpointed free list.
// master: rename + commit logic (drives requests, frees, save/restore).
// slave : the free list (drives tag availability, count and overflow flag).
interface phys_reg_free_list_ckpt_if;
  import core_types_pkg::*;

  logic               dequeue_req;
  logic               dequeue_valid;
  phys_reg_tag_t      dequeue_phys_reg_tag;
  logic               enqueue_valid;
  phys_reg_tag_t      enqueue_phys_reg_tag;
  logic               save_valid;
  checkpoint_column_t save_column;
  logic               restore_valid;
  checkpoint_column_t restore_column;
  free_count_t        free_count;
  logic               overflow_error;

  modport master (
    output dequeue_req, enqueue_valid, enqueue_phys_reg_tag,
           save_valid, save_column, restore_valid, restore_column,
    input  dequeue_valid, dequeue_phys_reg_tag, free_count, overflow_error
  );

  modport slave (
    input  dequeue_req, enqueue_valid, enqueue_phys_reg_tag,
           save_valid, save_column, restore_valid, restore_column,
    output dequeue_valid, dequeue_phys_reg_tag, free_count, overflow_error
  );

endinterface

// File: rtl/free_list_checkpoint_array.sv
// Head-pointer snapshot storage: CHECKPOINT_COLUMNS pointer registers with one
// write port (save) and one combinational read port (restore); reset to 0.
// Ports: clk, rst_n (async active-low), write_en/write_column/write_ptr,
//        read_column -> read_ptr.
module free_list_checkpoint_array
  import core_types_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               write_en,
  input  checkpoint_column_t write_column,
  input  free_list_ptr_t     write_ptr,
  input  checkpoint_column_t read_column,
  output free_list_ptr_t     read_ptr
);

  free_list_ptr_t column_q [CHECKPOINT_COLUMNS];

  // Snapshot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(CHECKPOINT_COLUMNS); i++) begin
        column_q[i] <= '0;
      end
    end else if (write_en) begin
      column_q[write_column] <= write_ptr;
    end
  end

  // Read sees the pre-edge contents, so a same-cycle save never leaks into a restore.
  assign read_ptr = column_q[read_column];

endmodule

// File: rtl/phys_reg_free_list_ckpt.sv
// Checkpointed physical-register free list for the rename stage.
// Circular array of free tags; rename dequeues at head (show-ahead), commit
// enqueues at tail, and a mispredict restores head from a saved column.
// Ports: CLK, nRST (async active-low), fl (phys_reg_free_list_ckpt_if.slave).
// Optional: FREE_LIST_BYPASS_EN lets an enqueue into an empty list be
// dequeued in the same cycle.
module phys_reg_free_list_ckpt
  import core_types_pkg::*;
(
  input  logic                      CLK,
  input  logic                      nRST,
  phys_reg_free_list_ckpt_if.slave  fl
);

  if ((FREE_LIST_DEPTH & (FREE_LIST_DEPTH - 1)) != 0) begin : g_depth_check
    $error("FREE_LIST_DEPTH must be a power of two");
  end

  phys_reg_tag_t  entries_q [FREE_LIST_DEPTH];
  free_list_ptr_t head_q, tail_q, head_d, tail_d;
  free_list_ptr_t save_ptr, ckpt_ptr;
  logic           overflow_q;
  logic           empty, full, bypass, pass_through;
  logic           dequeue_valid_c, deq_fire, enq_accept, overflow_set, save_en;
  free_list_enq_t enq;

  assign enq   = '{valid: fl.enqueue_valid, tag: fl.enqueue_phys_reg_tag};
  assign empty = (head_q == tail_q);
  assign full  = (ptr_idx(head_q) == ptr_idx(tail_q)) &&
                 (head_q[LOG_FREE_LIST_DEPTH] != tail_q[LOG_FREE_LIST_DEPTH]);

`ifdef FREE_LIST_BYPASS_EN
  // Forward a freed tag straight to rename when nothing else is available.
  assign bypass = empty && enq.valid && !fl.restore_valid;
`else
  assign bypass = 1'b0;
`endif

  assign pass_through    = bypass && fl.dequeue_req;
  assign dequeue_valid_c = !empty || bypass;

  // Restore wins over dequeue; a pass-through moves neither pointer.
  assign deq_fire     = fl.dequeue_req && dequeue_valid_c && !fl.restore_valid && !pass_through;
  assign enq_accept   = enq.valid && !pass_through && (!full || deq_fire);
  assign overflow_set = enq.valid && full && !deq_fire;
  assign save_ptr     = head_q + free_list_ptr_t'(deq_fire);
  assign save_en      = fl.save_valid &&
                        !(fl.restore_valid && (fl.save_column == fl.restore_column));

  assign head_d = fl.restore_valid ? ckpt_ptr : save_ptr;
  assign tail_d = tail_q + free_list_ptr_t'(enq_accept);

  // Outputs: combinational from registered state (plus bypass).
  assign fl.dequeue_valid        = dequeue_valid_c;
  assign fl.dequeue_phys_reg_tag = bypass ? enq.tag : entries_q[ptr_idx(head_q)];
  assign fl.free_count           = free_count_t'(tail_q - head_q);
  assign fl.overflow_error       = overflow_q;

  // Tag storage and pointers; reset fills the list with the non-architectural tags.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < int'(FREE_LIST_DEPTH); i++) begin
        entries_q[i] <= phys_reg_tag_t'(int'(NUM_ARCH_REGS) + i);
      end
      head_q     <= '0;
      tail_q     <= free_list_ptr_t'(FREE_LIST_DEPTH);
      overflow_q <= 1'b0;
    end else begin
      if (enq_accept) begin
        entries_q[ptr_idx(tail_q)] <= enq.tag;
      end
      head_q <= head_d;
      tail_q <= tail_d;
      if (overflow_set) begin
        overflow_q <= 1'b1;
      end
    end
  end

  free_list_checkpoint_array u_ckpt (
    .clk          (CLK),
    .rst_n        (nRST),
    .write_en     (save_en),
    .write_column (fl.save_column),
    .write_ptr    (save_ptr),
    .read_column  (fl.restore_column),
    .read_ptr     (ckpt_ptr)
  );

endmodule

// File: tb/tb_phys_reg_free_list_ckpt.sv
// Self-checking bench for phys_reg_free_list_ckpt. Reference model keeps
// tags in an unbounded position-keyed map with integer head/tail counters.
module tb_phys_reg_free_list_ckpt;
  import core_types_pkg::*;

  localparam int D = int'(FREE_LIST_DEPTH);
`ifdef FREE_LIST_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  phys_reg_free_list_ckpt_if fl_if ();

  phys_reg_free_list_ckpt dut (
    .CLK  (CLK),
    .nRST (nRST),
    .fl   (fl_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model
  int m_head, m_tail;
  int m_slot [int];
  int m_ck [CHECKPOINT_COLUMNS];
  bit m_ovf;

  function automatic int m_count();
    return m_tail - m_head;
  endfunction

  function automatic bit m_bypass();
    return BYP && (m_count() == 0) && fl_if.enqueue_valid && !fl_if.restore_valid;
  endfunction

  function automatic bit m_dv();
    return (m_count() != 0) || m_bypass();
  endfunction

  function automatic int m_tag();
    if (m_bypass()) return int'(fl_if.enqueue_phys_reg_tag);
    return m_slot[m_head];
  endfunction

  task automatic model_reset();
    m_slot.delete();
    for (int i = 0; i < D; i++) m_slot[i] = int'(NUM_ARCH_REGS) + i;
    m_head = 0;
    m_tail = D;
    for (int c = 0; c < int'(CHECKPOINT_COLUMNS); c++) m_ck[c] = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_step();
    int  cnt    = m_count();
    bit  dv     = m_dv();
    bit  deq, enq;
    int  old_ck = m_ck[fl_if.restore_column];
    deq = fl_if.dequeue_req && dv && !fl_if.restore_valid;
    if (m_bypass() && fl_if.dequeue_req) begin
      deq = 1'b0;
      enq = 1'b0;
    end else begin
      enq = fl_if.enqueue_valid && ((cnt != D) || deq);
      if (fl_if.enqueue_valid && !enq) m_ovf = 1'b1;
    end
    if (enq) begin
      m_slot[m_tail] = int'(fl_if.enqueue_phys_reg_tag);
      m_tail++;
    end
    if (deq) m_head++;
    if (fl_if.save_valid && !(fl_if.restore_valid && fl_if.save_column == fl_if.restore_column))
      m_ck[fl_if.save_column] = m_head;
    if (fl_if.restore_valid) m_head = old_ck;
  endtask

  task automatic set_in(input int req, input int ev, input int etag,
                        input int sv, input int scol, input int rv, input int rcol);
    fl_if.dequeue_req          = (req != 0);
    fl_if.enqueue_valid        = (ev != 0);
    fl_if.enqueue_phys_reg_tag = phys_reg_tag_t'(etag);
    fl_if.save_valid           = (sv != 0);
    fl_if.save_column          = checkpoint_column_t'(scol);
    fl_if.restore_valid        = (rv != 0);
    fl_if.restore_column       = checkpoint_column_t'(rcol);
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0);
    nRST = 1'b0;
    model_reset();
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (fl_if.dequeue_valid !== 1'b1) $display("FAIL reset_dv: got %0d expected 1", fl_if.dequeue_valid);
    else n_pass++;
    n_checks++;
    if (fl_if.dequeue_phys_reg_tag !== phys_reg_tag_t'(NUM_ARCH_REGS))
      $display("FAIL reset_tag: got %0d expected %0d", fl_if.dequeue_phys_reg_tag, NUM_ARCH_REGS);
    else n_pass++;
    n_checks++;
    if (fl_if.free_count !== free_count_t'(D)) $display("FAIL reset_count: got %0d expected %0d", fl_if.free_count, D);
    else n_pass++;
    n_checks++;
    if (fl_if.overflow_error !== 1'b0) $display("FAIL reset_ovf: got %0d expected 0", fl_if.overflow_error);
    else n_pass++;
  endtask

  task automatic test_drain();
    for (int i = 0; i < D; i++) begin
      set_in(1, 0, 0, 0, 0, 0, 0);
      #1;
      n_checks++;
      if (fl_if.dequeue_valid !== 1'b1 || fl_if.dequeue_phys_reg_tag !== phys_reg_tag_t'(32 + i))
        $display("FAIL drain_tag[%0d]: got v=%0d tag=%0d expected v=1 tag=%0d",
                 i, fl_if.dequeue_valid, fl_if.dequeue_phys_reg_tag, 32 + i);
      else n_pass++;
      tick();
    end
    set_in(1, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++;
    if (fl_if.dequeue_valid !== 1'b0 || fl_if.free_count !== '0)
      $display("FAIL drain_empty: got v=%0d count=%0d expected v=0 count=0", fl_if.dequeue_valid, fl_if.free_count);
    else n_pass++;
    tick();
    n_checks++;
    if (fl_if.free_count !== free_count_t'(m_count()) || fl_if.free_count !== '0)
      $display("FAIL empty_noop: got count=%0d expected 0", fl_if.free_count);
    else n_pass++;
  endtask

  task automatic test_enqueue_empty();
`ifdef FREE_LIST_BYPASS_EN
    set_in(1, 1, 40, 0, 0, 0, 0);
    #1;
    n_checks++;
    if (fl_if.dequeue_valid !== 1'b1 || fl_if.dequeue_phys_reg_tag !== phys_reg_tag_t'(40))
      $display("FAIL bypass_tag: got v=%0d tag=%0d expected v=1 tag=40", fl_if.dequeue_valid, fl_if.dequeue_phys_reg_tag);
    else n_pass++;
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++;
    if (fl_if.free_count !== '0 || fl_if.dequeue_valid !== 1'b0)
      $display("FAIL bypass_count: got count=%0d v=%0d expected count=0 v=0", fl_if.free_count, fl_if.dequeue_valid);
    else n_pass++;
`else
    set_in(1, 1, 40, 0, 0, 0, 0);
    #1;
    n_checks++;
    if (fl_if.dequeue_valid !== 1'b0) $display("FAIL nobypass_dv: got %0d expected 0", fl_if.dequeue_valid);
    else n_pass++;
    tick();
    set_in(1, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++;
    if (fl_if.dequeue_valid !== 1'b1 || fl_if.dequeue_phys_reg_tag !== phys_reg_tag_t'(40) || fl_if.free_count !== free_count_t'(1))
      $display("FAIL enq_then_deq: got v=%0d tag=%0d count=%0d expected v=1 tag=40 count=1",
               fl_if.dequeue_valid, fl_if.dequeue_phys_reg_tag, fl_if.free_count);
    else n_pass++;
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++;
    if (fl_if.free_count !== '0 || fl_if.dequeue_valid !== 1'b0)
      $display("FAIL enq_deq_empty: got count=%0d v=%0d expected 0 0", fl_if.free_count, fl_if.dequeue_valid);
    else n_pass++;
`endif
  endtask

  task automatic test_checkpoint_restore();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 0, 0, 0, 0, 0);
      #1;
      n_checks++;
      if (fl_if.dequeue_phys_reg_tag !== phys_reg_tag_t'(32 + i))
        $display("FAIL ckpt_pre[%0d]: got %0d expected %0d", i, fl_if.dequeue_phys_reg_tag, 32 + i);
      else n_pass++;
      tick();
    end
    set_in(0, 0, 0, 1, 2, 0, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      set_in(1, 0, 0, 0, 0, 0, 0);
      #1;
      n_checks++;
      if (fl_if.dequeue_phys_reg_tag !== phys_reg_tag_t'(35 + i))
        $display("FAIL ckpt_post[%0d]: got %0d expected %0d", i, fl_if.dequeue_phys_reg_tag, 35 + i);
      else n_pass++;
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++;
    if (fl_if.free_count !== free_count_t'(27)) $display("FAIL ckpt_before_restore: got %0d expected 27", fl_if.free_count);
    else n_pass++;
    set_in(0, 0, 0, 0, 0, 1, 2);
    tick();
    set_in(1, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++;
    if (fl_if.dequeue_phys_reg_tag !== phys_reg_tag_t'(35) || fl_if.free_count !== free_count_t'(29))
      $display("FAIL ckpt_restore: got tag=%0d count=%0d expected tag=35 count=29",
               fl_if.dequeue_phys_reg_tag, fl_if.free_count);
    else n_pass++;
    tick();
  endtask

  task automatic test_restore_concurrent();
    // head=4 now, column 2 holds 3; restore while enqueueing and requesting.
    set_in(1, 1, 10, 0, 0, 1, 2);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++;
    if (fl_if.free_count !== free_count_t'(30) || fl_if.dequeue_phys_reg_tag !== phys_reg_tag_t'(35))
      $display("FAIL restore_concurrent: got count=%0d tag=%0d expected count=30 tag=35",
               fl_if.free_count, fl_if.dequeue_phys_reg_tag);
    else n_pass++;
    // The freed tag sits at the very end of the list.
    for (int i = 0; i < 29; i++) begin
      set_in(1, 0, 0, 0, 0, 0, 0);
      tick();
    end
    set_in(1, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++;
    if (fl_if.dequeue_phys_reg_tag !== phys_reg_tag_t'(10) || fl_if.free_count !== free_count_t'(1))
      $display("FAIL restore_enq_tail: got tag=%0d count=%0d expected tag=10 count=1",
               fl_if.dequeue_phys_reg_tag, fl_if.free_count);
    else n_pass++;
    tick();
  endtask

  task automatic test_wrap();
    phys_reg_tag_t t;
    int bad_tag = 0, bad_cnt = 0;
    do_reset();
    for (int p = 0; p < 100; p++) begin
      set_in(1, 0, 0, 0, 0, 0, 0);
      #1;
      t = fl_if.dequeue_phys_reg_tag;
      if (fl_if.dequeue_valid !== 1'b1 || t !== phys_reg_tag_t'(m_tag())) begin
        if (bad_tag == 0) $display("FAIL wrap_tag[%0d]: got %0d expected %0d", p, t, m_tag());
        bad_tag++;
      end
      tick();
      set_in(0, 1, int'(t), 0, 0, 0, 0);
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0);
      #1;
      if (fl_if.free_count !== free_count_t'(D)) begin
        if (bad_cnt == 0) $display("FAIL wrap_count[%0d]: got %0d expected %0d", p, fl_if.free_count, D);
        bad_cnt++;
      end
    end
    n_checks++;
    if (bad_tag != 0) $display("FAIL wrap_order: got %0d bad tags expected 0", bad_tag);
    else n_pass++;
    n_checks++;
    if (bad_cnt != 0) $display("FAIL wrap_const: got %0d bad counts expected 0", bad_cnt);
    else n_pass++;
  endtask

  task automatic test_full();
    do_reset();
    set_in(1, 1, 7, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++;
    if (fl_if.overflow_error !== 1'b0 || fl_if.free_count !== free_count_t'(D))
      $display("FAIL full_deq_enq: got ovf=%0d count=%0d expected ovf=0 count=%0d", fl_if.overflow_error, fl_if.free_count, D);
    else n_pass++;
    set_in(0, 1, 9, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++;
    if (fl_if.overflow_error !== 1'b1 || fl_if.free_count !== free_count_t'(D))
      $display("FAIL full_overflow: got ovf=%0d count=%0d expected ovf=1 count=%0d", fl_if.overflow_error, fl_if.free_count, D);
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if (fl_if.overflow_error !== 1'b1 || fl_if.free_count !== free_count_t'(D))
      $display("FAIL full_sticky: got ovf=%0d count=%0d expected ovf=1 count=%0d", fl_if.overflow_error, fl_if.free_count, D);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      set_in(1, 0, 0, 0, 0, 0, 0);
      tick();
    end
    set_in(1, 1, 3, 1, 1, 0, 0);
    nRST = 1'b0;
    #1;
    n_checks++;
    if (fl_if.free_count !== free_count_t'(D) || fl_if.dequeue_valid !== 1'b1 ||
        fl_if.dequeue_phys_reg_tag !== phys_reg_tag_t'(NUM_ARCH_REGS) || fl_if.overflow_error !== 1'b0)
      $display("FAIL reset_mid: got count=%0d v=%0d tag=%0d ovf=%0d expected %0d 1 %0d 0",
               fl_if.free_count, fl_if.dequeue_valid, fl_if.dequeue_phys_reg_tag, fl_if.overflow_error, D, NUM_ARCH_REGS);
    else n_pass++;
    model_reset();
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    #1;
  endtask

  task automatic test_random();
    int req, ev, etag, sv, scol, rv, rcol, c;
    int bad = 0;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      req  = int'($urandom_range(0, 1));
      ev   = (m_count() < 4) ? int'($urandom_range(0, 3) != 0) : int'($urandom_range(0, 2) == 0);
      etag = int'($urandom_range(0, NUM_PHYS_REGS - 1));
      sv   = int'($urandom_range(0, 3) == 0);
      scol = int'($urandom_range(0, CHECKPOINT_COLUMNS - 1));
      rcol = int'($urandom_range(0, CHECKPOINT_COLUMNS - 1));
      c    = m_ck[rcol];
      rv   = int'(($urandom_range(0, 7) == 0) && (c <= m_head) && (m_tail + 1 - c <= D));
      set_in(req, ev, etag, sv, scol, rv, rcol);
      #1;
      n_checks++;
      if (fl_if.dequeue_valid !== m_dv() || fl_if.free_count !== free_count_t'(m_count()) ||
          fl_if.overflow_error !== m_ovf ||
          (m_dv() && fl_if.dequeue_phys_reg_tag !== phys_reg_tag_t'(m_tag()))) begin
        if (bad < 5)
          $display("FAIL random[%0d]: got v=%0d tag=%0d count=%0d ovf=%0d expected v=%0d tag=%0d count=%0d ovf=%0d",
                   k, fl_if.dequeue_valid, fl_if.dequeue_phys_reg_tag, fl_if.free_count, fl_if.overflow_error,
                   m_dv(), m_dv() ? m_tag() : 0, m_count(), m_ovf);
        bad++;
      end else n_pass++;
      tick();
    end
  endtask

  initial begin
    nRST = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_drain();
    test_enqueue_empty();
    test_checkpoint_restore();
    test_restore_concurrent();
    test_wrap();
    test_full();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
